image_stream_to_axis: RTL

- Downstream stage of the median-filter pipeline. Consumes the filter's free-running valid/pixel stream (valid_o/img_data_o, 24-bit replicated grey).
- Tags each pixel with frame and line position and buffers it in a small FIFO.
- Presents the pixels as an AXI4-Stream video master (tuser = start of frame, tlast = end of line) for the VDMA write path.
- Absorbs short sink stalls. The input side has no backpressure.

---
 rtl/image_stream_to_axis.sv | 79 +++++++
 1 files changed

// File: rtl/image_stream_to_axis.sv
// image_stream_to_axis: tags a free-running pixel stream with frame/line position
// and buffers it in a FIFO that drives an AXI4-Stream video master.
module image_stream_to_axis #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       img_width,
  input  logic [9:0]        img_height,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] img_data_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              overflow_o,
  output logic              frame_done_o,
  output logic [LVL_W-1:0]  fifo_level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);
  logic [10:0]       r_x, r_w_s, w_w;
  logic [9:0]        r_y, r_h_s, w_h;
  logic              w_first, w_eol, w_eof, w_push, w_pop;
  logic [DATA_W+2:0] r_mem [FIFO_DEPTH];
  logic [DATA_W+2:0] w_head;
  logic [AW-1:0]     r_wr, r_rd;
  logic [LVL_W-1:0]  r_cnt;
  logic              r_ov, r_fd;
  // the (0,0) pixel is tagged against the live geometry it is about to latch
  always_comb begin
    w_first = r_x == '0 && r_y == '0;
    w_w     = w_first ? img_width : r_w_s;
    w_h     = w_first ? img_height : r_h_s;
    w_eol   = r_x == w_w - 11'd1;
    w_eof   = w_eol && r_y == w_h - 10'd1;
    w_head  = r_mem[r_rd];
    w_pop   = m_axis_tvalid && m_axis_tready;
    w_push  = valid_i && (r_cnt != FULL || w_pop);
  end
  assign m_axis_tvalid = r_cnt != '0;
  assign m_axis_tdata  = m_axis_tvalid ? w_head[DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head[DATA_W];
  assign m_axis_tuser  = m_axis_tvalid & w_head[DATA_W+1];
  assign overflow_o    = r_ov;
  assign frame_done_o  = r_fd;
  assign fifo_level_o  = r_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_w_s <= '0;
      r_h_s <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ov  <= 1'b0;
      r_fd  <= 1'b0;
    end else begin
      if (valid_i) begin
        if (w_first) begin
          r_w_s <= img_width;
          r_h_s <= img_height;
        end
        r_x <= w_eol ? '0 : r_x + 11'd1;
        if (w_eol) r_y <= (r_y == w_h - 10'd1) ? '0 : r_y + 10'd1;
      end
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + LVL_W'(w_push) - LVL_W'(w_pop);
      r_ov  <= r_ov | (valid_i & ~w_push);
      r_fd  <= w_pop & w_head[DATA_W+2];
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= {w_eof, w_first, w_eol, img_data_i};
endmodule
